// File: rtl/xif_drv_pkg.sv
// Shared types and constants for the X-interface offload driver.
package xif_drv_pkg;

    localparam int unsigned XIF_ID_WIDTH_DEFAULT = 4;
    localparam int unsigned XLEN                 = 32;
    localparam int unsigned RD_WIDTH             = 5;
    localparam logic [1:0]  XIF_MODE_M           = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_COMMIT,
        S_RESULT,
        S_RESP
    } state_e;

    typedef struct packed {
        logic                accept;
        logic [XLEN-1:0]     data;
        logic [RD_WIDTH-1:0] rd;
        logic                we;
        logic                err;
    } resp_t;

endpackage

// File: rtl/if_xif.sv
// Issue/commit/result channels between the CPU-side driver and a coprocessor.
interface if_xif
    import xif_drv_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH_DEFAULT
);
    logic                      issue_valid;
    logic                      issue_ready;
    logic [XLEN-1:0]           issue_instr;
    logic [1:0][XLEN-1:0]      issue_rs;
    logic [1:0]                issue_rs_valid;
    logic [X_ID_WIDTH-1:0]     issue_id;
    logic [1:0]                issue_mode;
    logic                      issue_accept;

    logic                      commit_valid;
    logic [X_ID_WIDTH-1:0]     commit_id;
    logic                      commit_kill;

    logic                      result_valid;
    logic                      result_ready;
    logic [X_ID_WIDTH-1:0]     result_id;
    logic [XLEN-1:0]           result_data;
    logic [RD_WIDTH-1:0]       result_rd;
    logic                      result_we;
    logic                      result_exc;

    modport cpu_issue (
        output issue_valid, issue_instr, issue_rs, issue_rs_valid, issue_id, issue_mode,
        input  issue_ready, issue_accept
    );

    modport cpu_commit (
        output commit_valid, commit_id, commit_kill
    );

    modport cpu_result (
        input  result_valid, result_id, result_data, result_rd, result_we, result_exc,
        output result_ready
    );

endinterface

// File: rtl/xif_drv_timeout.sv
// Clearable saturating wait counter; expired_c flags the MAX_COUNT-th waiting cycle.
module xif_drv_timeout #(
    parameter int unsigned MAX_COUNT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != CNT_W'(MAX_COUNT))) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_c = (count_q >= CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/xif_offload_driver.sv
// Drives one offloaded instruction at a time through issue, commit and result
// channels and returns a single-cycle response to the local requester.
module xif_offload_driver
    import xif_drv_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH     = XIF_ID_WIDTH_DEFAULT,
    parameter int unsigned RESULT_TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    if_xif.cpu_issue            xif_issue,
    if_xif.cpu_commit           xif_commit,
    if_xif.cpu_result           xif_result,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [XLEN-1:0]     req_instr_i,
    input  logic [XLEN-1:0]     req_rs1_i,
    input  logic [XLEN-1:0]     req_rs2_i,
    output logic                resp_valid_o,
    output logic                resp_accept_o,
    output logic [XLEN-1:0]     resp_data_o,
    output logic [RD_WIDTH-1:0] resp_rd_o,
    output logic                resp_we_o,
    output logic                resp_err_o,
    output logic                busy_o
);

    state_e                state_q, state_d;
    logic [XLEN-1:0]       instr_q, rs1_q, rs2_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic                  accept_q, accept_d;
    logic                  tmo_load, tmo_en, tmo_expired;
    resp_t                 resp_q, resp_d;
    logic                  req_ready_q, busy_q, issue_valid_q, commit_valid_q;
    logic                  result_ready_q, resp_valid_q;

    xif_drv_timeout #(
        .MAX_COUNT (RESULT_TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (tmo_load),
        .en_i      (tmo_en),
        .expired_c (tmo_expired)
    );

    // Next state plus the response payload captured on entry to RESP.
    always_comb begin
        state_d  = state_q;
        accept_d = accept_q;
        tmo_load = 1'b0;
        tmo_en   = 1'b0;
        resp_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (xif_issue.issue_ready) begin
                    accept_d = xif_issue.issue_accept;
                    state_d  = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (accept_q) begin
                    tmo_load = 1'b1;
                    state_d  = S_RESULT;
                end else begin
                    state_d  = S_RESP;
                end
            end
            S_RESULT: begin
                if (xif_result.result_valid) begin
                    resp_d.accept = 1'b1;
                    resp_d.data   = xif_result.result_data;
                    resp_d.rd     = xif_result.result_rd;
                    resp_d.we     = xif_result.result_we;
                    resp_d.err    = xif_result.result_exc | (xif_result.result_id != id_q);
                    state_d       = S_RESP;
                end else if (tmo_expired) begin
                    resp_d.accept = 1'b1;
                    resp_d.err    = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // id_q only advances on leaving RESP, so it is the issued ID while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            accept_q <= 1'b0;
            id_q     <= '0;
            instr_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            state_q  <= state_d;
            accept_q <= accept_d;
            if ((state_q == S_IDLE) && req_valid_i) begin
                instr_q <= req_instr_i;
                rs1_q   <= req_rs1_i;
                rs2_q   <= req_rs2_i;
            end
            if (state_q == S_RESP) id_q <= id_q + X_ID_WIDTH'(1);
        end
    end

    // Handshake outputs registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            issue_valid_q  <= 1'b0;
            commit_valid_q <= 1'b0;
            result_ready_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_q         <= '0;
        end else begin
            req_ready_q    <= (state_d == S_IDLE);
            busy_q         <= (state_d != S_IDLE);
            issue_valid_q  <= (state_d == S_ISSUE);
            commit_valid_q <= (state_d == S_COMMIT);
            result_ready_q <= (state_d == S_RESULT);
            resp_valid_q   <= (state_d == S_RESP);
            resp_q         <= resp_d;
        end
    end

    assign xif_issue.issue_valid    = issue_valid_q;
    assign xif_issue.issue_instr    = instr_q;
    assign xif_issue.issue_rs       = {rs2_q, rs1_q};
    assign xif_issue.issue_rs_valid = 2'b11;
    assign xif_issue.issue_id       = id_q;
    assign xif_issue.issue_mode     = XIF_MODE_M;

    assign xif_commit.commit_valid  = commit_valid_q;
    assign xif_commit.commit_id     = id_q;
    assign xif_commit.commit_kill   = !accept_q;

    assign xif_result.result_ready  = result_ready_q;

    assign req_ready_o   = req_ready_q;
    assign busy_o        = busy_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_accept_o = resp_q.accept;
    assign resp_data_o   = resp_q.data;
    assign resp_rd_o     = resp_q.rd;
    assign resp_we_o     = resp_q.we;
    assign resp_err_o    = resp_q.err;

endmodule

// File: doc/xif_offload_driver.md
XIF_OFFLOAD_DRIVER -- requirements
Module: xif_offload_driver

Interface
REQ-001 The block SHALL have parameter X_ID_WIDTH, default 4: width of the transaction ID.
REQ-002 The block SHALL have parameter RESULT_TIMEOUT, default 255: maximum number of cycles spent waiting for a result.
REQ-003 The block SHALL run on one clock, clk_i; reset is asynchronous and active-low on rst_ni.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- xif_issue  if_xif.cpu_issue  -  issue channel, initiator side
- xif_commit  if_xif.cpu_commit  -  commit channel, initiator side
- xif_result  if_xif.cpu_result  -  result channel, initiator side
- req_valid_i  in  1  local offload request valid
- req_ready_o  out  1  local request accepted
- req_instr_i  in  32  instruction word
- req_rs1_i, req_rs2_i  in  32  operand values
- resp_valid_o  out  1  response pulse, one cycle
- resp_accept_o  out  1  coprocessor accepted the instruction
- resp_data_o  out  32  result data
- resp_rd_o  out  5  result destination register
- resp_we_o  out  1  result write-enable
- resp_err_o  out  1  result exc, ID mismatch or timeout
- busy_o  out  1  FSM not in IDLE

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, COMMIT, RESULT and RESP, and SHALL handle one transaction in flight at a time.
REQ-006 In IDLE, req_ready_o SHALL be 1; on req_valid_i the block SHALL latch instr, rs1, rs2 and the current ID, then move to ISSUE.
REQ-007 In ISSUE, issue_valid SHALL be 1 and issue_req (instr, rs[0]/rs[1], rs_valid=all ones, id, mode=M) SHALL be held stable until issue_ready.
REQ-008 On the issue handshake, the block SHALL latch issue_resp.accept and move to COMMIT.
REQ-009 In COMMIT, commit_valid SHALL be 1 for exactly one cycle, with commit.id equal to the issued ID and commit_kill = NOT accept.
REQ-010 After COMMIT, the block SHALL go to RESULT if accepted, else to RESP with resp_accept_o=0 and data, rd and we all 0.
REQ-011 In RESULT, result_ready SHALL be 1; result_ready SHALL be 0 in every other state.
REQ-012 On result_valid in RESULT, the block SHALL latch data, rd, we and exc, and move to RESP.
REQ-013 If result.id differs from the issued ID, the block SHALL still consume the result and SHALL set resp_err_o=1.
REQ-014 A timeout counter SHALL clear on entry to RESULT and increment each waiting cycle.
REQ-015 If the counter reaches RESULT_TIMEOUT, the block SHALL go to RESP with resp_err_o=1, resp_accept_o=1 and data/we zeroed.
REQ-016 If result_valid and timeout occur in the same cycle, the result SHALL win.
REQ-017 In RESP, resp_valid_o SHALL be 1 for one cycle; the ID counter SHALL then increment, modulo 2^X_ID_WIDTH, and the FSM SHALL return to IDLE.
REQ-018 Latency from request to response SHALL be: no wait states, accepted = 5 cycles; rejected = 4 cycles.
REQ-019 result_valid outside RESULT SHALL be ignored, and no state SHALL change.
REQ-020 req_valid_i while busy SHALL be ignored (req_ready_o=0).

Reset
REQ-021 While rst_ni is low: state=IDLE, ID=0, timeout counter=0, and all outputs 0 except req_ready_o=1 after release.
REQ-022 Reset mid-transaction SHALL abandon the transaction immediately, with no commit or response emitted.

Structure
REQ-023 A shared package xif_drv_pkg SHALL hold the state enum, the default X_ID_WIDTH and the mode constant.
REQ-024 The only sub-module SHALL be xif_drv_timeout, a loadable saturating counter for RESULT_TIMEOUT.

Verification
REQ-025 Accept path: instr 0x0000006F, coprocessor ready+accept, result id 0 and data 0xDEADBEEF one cycle later -> resp_valid, accept=1, data=0xDEADBEEF, commit_kill=0.
REQ-026 Reject path: issue_ready=1, accept=0 -> commit_kill=1, resp accept=0, no result_ready asserted.
REQ-027 Backpressure: issue_ready held low for 10 cycles -> issue_req stable throughout, then normal completion.
REQ-028 ID wrap: 17 back-to-back transactions -> IDs 0..15, then 0; commit.id matches each time.
REQ-029 Timeout: accept, no result -> resp_err_o=1 after exactly RESULT_TIMEOUT cycles in RESULT, FSM in IDLE.
REQ-030 ID mismatch and reset: result.id=3 while expecting 2 -> resp_err_o=1; rst_ni pulse during RESULT -> IDLE, no resp_valid.
